// File: rtl/vector_stats_responder_if.sv
// Column handshake between a column sequencer (master) and a statistics responder (slave).
interface vector_stats_responder_if #(
  parameter int D_MODEL   = 128,
  parameter int X_WIDTH   = 16,
  parameter int OUT_WIDTH = 24
);
  logic                         start_in;
  logic [D_MODEL*X_WIDTH-1:0]   x_vector_flat_in;
  logic                         busy_out;
  logic                         done_valid_out;
  logic [OUT_WIDTH-1:0]         mean_out;
  logic [OUT_WIDTH-1:0]         var_out;

  modport master (
    output start_in,
    output x_vector_flat_in,
    input  busy_out,
    input  done_valid_out,
    input  mean_out,
    input  var_out
  );

  modport slave (
    input  start_in,
    input  x_vector_flat_in,
    output busy_out,
    output done_valid_out,
    output mean_out,
    output var_out
  );
endinterface

// File: rtl/vector_stats_responder.sv
// Serial column statistics engine: accumulates sum and sum-of-squares one element per
// cycle, then returns floor mean and clamped population variance with a done pulse.
module vector_stats_responder #(
  parameter int D_MODEL   = 128,
  parameter int LOG2_D    = 7,
  parameter int X_WIDTH   = 16,
  parameter int X_FRAC    = 10,
  parameter int OUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  vector_stats_responder_if.slave  bus
);

  localparam int SUM_W  = X_WIDTH + LOG2_D;
  localparam int SQ_W   = 2 * X_WIDTH + LOG2_D;
  localparam int PROD_W = 2 * X_WIDTH;
  localparam int V_W    = PROD_W + 1;
  localparam int CMP_W  = ((V_W > OUT_WIDTH) ? V_W : OUT_WIDTH) + 1;
  localparam logic signed [CMP_W-1:0] SAT_MAX = (CMP_W'(1) <<< (OUT_WIDTH - 1)) - CMP_W'(1);
  localparam logic [LOG2_D-1:0] LAST_IDX = LOG2_D'(D_MODEL - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    MEAN,
    VAR,
    DONE
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic                        accept;

  logic [D_MODEL*X_WIDTH-1:0]  vec_r;
  logic [LOG2_D-1:0]           idx;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SQ_W-1:0]      sumsq;
  logic signed [X_WIDTH-1:0]   mean_r;
  logic [OUT_WIDTH-1:0]        var_r;

  logic signed [X_WIDTH-1:0]   cur_x;
  logic signed [PROD_W-1:0]    cur_sq;
  logic signed [PROD_W-1:0]    ex2;
  logic signed [PROD_W-1:0]    mean_sq;
  logic signed [V_W-1:0]       v;
  logic signed [V_W-1:0]       v_shift;
  logic [OUT_WIDTH-1:0]        var_calc;

  logic                        busy_q;
  logic                        done_q;
  logic [OUT_WIDTH-1:0]        mean_q;
  logic [OUT_WIDTH-1:0]        var_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start_in is only honoured in IDLE and DONE; a request while busy is dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_in) begin
          accept     = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (idx == LAST_IDX) begin
          state_next = MEAN;
        end
      end
      MEAN: state_next = VAR;
      VAR:  state_next = DONE;
      DONE: begin
        if (bus.start_in) begin
          accept     = 1'b1;
          state_next = ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cur_x  = vec_r[idx*X_WIDTH +: X_WIDTH];
  assign cur_sq = cur_x * cur_x;

  // Variance in 2*X_FRAC fraction, rescaled to X_FRAC; rounding can make it negative.
  always_comb begin
    ex2      = PROD_W'(sumsq >>> LOG2_D);
    mean_sq  = mean_r * mean_r;
    v        = V_W'(ex2) - V_W'(mean_sq);
    v_shift  = v >>> X_FRAC;
    var_calc = OUT_WIDTH'(v_shift);
    if (v < 0) begin
      var_calc = '0;
    end else if (CMP_W'(v_shift) > SAT_MAX) begin
      var_calc = OUT_WIDTH'(SAT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r  <= '0;
      idx    <= '0;
      sum    <= '0;
      sumsq  <= '0;
      mean_r <= '0;
      var_r  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          sum   <= sum + SUM_W'(cur_x);
          sumsq <= sumsq + SQ_W'(cur_sq);
          idx   <= idx + LOG2_D'(1);
        end
        MEAN: mean_r <= X_WIDTH'(sum >>> LOG2_D);
        VAR:  var_r  <= var_calc;
        default: ;
      endcase
      if (accept) begin
        vec_r <= bus.x_vector_flat_in;
        sum   <= '0;
        sumsq <= '0;
        idx   <= '0;
      end
    end
  end

  // Result registers lag DONE by one edge, so busy is held through the pulse cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mean_q <= '0;
      var_q  <= '0;
    end else begin
      busy_q <= (state_next != IDLE) || (state == DONE);
      done_q <= (state == DONE);
      if (state == DONE) begin
        mean_q <= OUT_WIDTH'(mean_r);
        var_q  <= var_r;
      end
    end
  end

  assign bus.busy_out       = busy_q;
  assign bus.done_valid_out = done_q;
  assign bus.mean_out       = mean_q;
  assign bus.var_out        = var_q;

endmodule

// File: tb/tb_vector_stats_responder.sv
// Self-checking bench for vector_stats_responder: directed plan vectors plus random
// columns checked against an arithmetic reference model.
module tb_vector_stats_responder;

  localparam int D   = 128;
  localparam int XW  = 16;
  localparam int OW  = 24;
  localparam int VW  = D * XW;
  localparam int LAT = 131;

  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  vector_stats_responder_if #(.D_MODEL(D), .X_WIDTH(XW), .OUT_WIDTH(OW)) bus ();

  vector_stats_responder #(
    .D_MODEL(D), .LOG2_D(7), .X_WIDTH(XW), .X_FRAC(10), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t make_alt(input logic [XW-1:0] even_v, input logic [XW-1:0] odd_v);
    vec_t v;
    for (int i = 0; i < D; i++) v[i*XW +: XW] = (i % 2 == 0) ? even_v : odd_v;
    return v;
  endfunction

  function automatic vec_t make_rand();
    vec_t v;
    for (int i = 0; i < D; i++) v[i*XW +: XW] = XW'($urandom);
    return v;
  endfunction

  // Reference: floor(sum/D), floor(E[x^2]) - mean^2 rescaled, negative clamped to zero.
  function automatic void model(input vec_t v, output logic [OW-1:0] m, output logic [OW-1:0] va);
    longint s, sq, q, ex2, vv, r;
    logic signed [XW-1:0] e;
    s = 0; sq = 0;
    for (int i = 0; i < D; i++) begin
      e  = v[i*XW +: XW];
      s  += longint'(e);
      sq += longint'(e) * longint'(e);
    end
    q = s / D;
    if ((s % D) != 0 && s < 0) q = q - 1;
    ex2 = sq / D;
    vv  = ex2 - q * q;
    if (vv < 0) r = 0;
    else r = vv / 1024;
    if (r > 64'sd8388607) r = 64'sd8388607;
    m  = q[OW-1:0];
    va = r[OW-1:0];
  endfunction

  task automatic start_column(input vec_t v);
    @(negedge clk);
    bus.x_vector_flat_in = v;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.x_vector_flat_in = make_rand();
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.done_valid_out === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int stray;
    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.x_vector_flat_in = make_rand();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_out);
    end
    tests_run++;
    if (bus.mean_out !== '0 || bus.var_out !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_outputs: got mean %h var %h expected 0 0", bus.mean_out, bus.var_out);
    end
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done_valid_out !== 1'b0) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++; $display("[TB] FAIL reset_no_done: got %0d pulses expected 0", stray);
    end
  endtask

  task automatic test_directed(input string name, input vec_t v,
                               input logic [OW-1:0] exp_m, input logic [OW-1:0] exp_v);
    int edges;
    start_column(v);
    wait_done(edges);
    tests_run++;
    if (edges !== LAT) begin
      tests_failed++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, edges, LAT);
    end
    tests_run++;
    if (bus.mean_out !== exp_m) begin
      tests_failed++; $display("[TB] FAIL %s_mean: got %h expected %h", name, bus.mean_out, exp_m);
    end
    tests_run++;
    if (bus.var_out !== exp_v) begin
      tests_failed++; $display("[TB] FAIL %s_var: got %h expected %h", name, bus.var_out, exp_v);
    end
    tests_run++;
    if (bus.busy_out !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL %s_busy_at_done: got %b expected 1", name, bus.busy_out);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL %s_after_done: got done %b busy %b expected 0 0", name, bus.done_valid_out, bus.busy_out);
    end
  endtask

  task automatic test_random();
    vec_t v;
    int edges;
    logic [OW-1:0] m, va;
    for (int n = 0; n < 6; n++) begin
      v = make_rand();
      if (n >= 3) begin
        for (int i = 0; i < D; i++) v[i*XW +: XW] = XW'($urandom_range(0, 4095)) - XW'(16'd1024);
      end
      model(v, m, va);
      start_column(v);
      wait_done(edges);
      tests_run++;
      if (edges !== LAT || bus.mean_out !== m || bus.var_out !== va) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: got edges %0d mean %h var %h expected %0d %h %h", n, edges, bus.mean_out, bus.var_out, LAT, m, va);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.mean_out !== m || bus.var_out !== va || bus.done_valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL random_hold: got mean %h var %h done %b expected %h %h 0", bus.mean_out, bus.var_out, bus.done_valid_out, m, va);
    end
  endtask

  task automatic test_ignore_start();
    vec_t a, b;
    int edges, extra;
    logic [OW-1:0] m, va;
    a = make_rand();
    b = make_alt(16'h7000, 16'h9000);
    model(a, m, va);
    start_column(a);
    repeat (10) @(negedge clk);
    bus.x_vector_flat_in = b;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.x_vector_flat_in = make_rand();
    wait_done(edges);
    tests_run++;
    if (edges !== LAT - 11) begin
      tests_failed++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", edges, LAT - 11);
    end
    tests_run++;
    if (bus.mean_out !== m || bus.var_out !== va) begin
      tests_failed++; $display("[TB] FAIL ignore_result: got %h %h expected %h %h", bus.mean_out, bus.var_out, m, va);
    end
    extra = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done_valid_out === 1'b1) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++; $display("[TB] FAIL ignore_not_queued: got %0d pulses expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    int edges, busy_low;
    logic [OW-1:0] ma, va_a, mb, va_b;
    a = make_rand();
    b = make_alt(16'h0C00, 16'hF800);
    model(a, ma, va_a);
    model(b, mb, va_b);
    start_column(a);
    repeat (128) @(negedge clk);
    bus.x_vector_flat_in = b;
    bus.start_in = 1'b1;
    wait_done(edges);
    bus.start_in = 1'b0;
    bus.x_vector_flat_in = make_rand();
    tests_run++;
    if (edges !== 3 || bus.mean_out !== ma || bus.var_out !== va_a) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got edges %0d mean %h var %h expected 3 %h %h", edges, bus.mean_out, bus.var_out, ma, va_a);
    end
    busy_low = 0;
    edges = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.busy_out !== 1'b1) busy_low++;
      if (bus.done_valid_out === 1'b1) begin
        edges = k;
        break;
      end
    end
    tests_run++;
    if (edges !== LAT) begin
      tests_failed++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", edges, LAT);
    end
    tests_run++;
    if (busy_low !== 0) begin
      tests_failed++; $display("[TB] FAIL b2b_busy: got %0d low cycles expected 0", busy_low);
    end
    tests_run++;
    if (bus.mean_out !== mb || bus.var_out !== va_b) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got %h %h expected %h %h", bus.mean_out, bus.var_out, mb, va_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    vec_t a, c;
    int stray, edges;
    logic [OW-1:0] m, va;
    a = make_rand();
    c = make_rand();
    model(c, m, va);
    start_column(a);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.busy_out !== 1'b0 || bus.done_valid_out !== 1'b0 || bus.mean_out !== '0 || bus.var_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear: got busy %b done %b mean %h var %h expected 0 0 0 0", bus.busy_out, bus.done_valid_out, bus.mean_out, bus.var_out);
    end
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done_valid_out === 1'b1) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", stray);
    end
    start_column(c);
    wait_done(edges);
    tests_run++;
    if (edges !== LAT || bus.mean_out !== m || bus.var_out !== va) begin
      tests_failed++;
      $display("[TB] FAIL midreset_fresh: got edges %0d mean %h var %h expected %0d %h %h", edges, bus.mean_out, bus.var_out, LAT, m, va);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    bus.x_vector_flat_in = '0;
    test_reset();
    test_directed("alt", make_alt(16'h0800, 16'h0200), 24'h000500, 24'h000240);
    test_directed("const_pos", make_alt(16'h0400, 16'h0400), 24'h000400, 24'h000000);
    test_directed("const_neg", make_alt(16'h8000, 16'h8000), 24'hFF8000, 24'h000000);
    test_directed("pm_one", make_alt(16'h0400, 16'hFC00), 24'h000000, 24'h000400);
    test_directed("floor", vec_t'(16'hFFFF), 24'hFFFFFF, 24'h000000);
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
